// File: rtl/ewb_fifo_pkg.sv
// Shared types for the eviction write buffer: line/address types and drain FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ewb_fifo_pkg;

  typedef logic [127:0] lc3b_cline;
  typedef logic [11:0]  lc3b_cline_addr;

  localparam int EWB_DEPTH_DEF  = 4;
  localparam int EWB_DATA_W_DEF = $bits(lc3b_cline);
  localparam int EWB_ADDR_W_DEF = $bits(lc3b_cline_addr);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RETIRE = 2'd2
  } ewb_state_t;

endpackage

// File: rtl/ewb_fifo_if.sv
// Bundle of L2-side push/lookup signals and memory-side drain signals of the write buffer.
// Latency: n/a (wiring only).
// Backpressure: wr_req held by L2 until wr_ack; mem_req held by the buffer until mem_ack.
interface ewb_fifo_if
  import ewb_fifo_pkg::*;
#(
  parameter int DEPTH  = EWB_DEPTH_DEF,
  parameter int ADDR_W = EWB_ADDR_W_DEF,
  parameter int DATA_W = EWB_DATA_W_DEF
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_conflict;
  logic              rd_fwd_valid;
  logic [DATA_W-1:0] rd_fwd_data;
  logic              l2_mem_busy;
  logic              ewb_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;

  // Buffer side
  modport slave (
    input  wr_req, wr_addr, wr_data, rd_addr, l2_mem_busy, mem_ack,
    output wr_ack, full, empty, count, rd_conflict, rd_fwd_valid, rd_fwd_data,
           ewb_busy, mem_req, mem_addr, mem_data
  );

  // L2 / memory side
  modport master (
    output wr_req, wr_addr, wr_data, rd_addr, l2_mem_busy, mem_ack,
    input  wr_ack, full, empty, count, rd_conflict, rd_fwd_valid, rd_fwd_data,
           ewb_busy, mem_req, mem_addr, mem_data
  );

endinterface

// File: rtl/ewb_fifo_match.sv
// DEPTH-way line-address comparator: one-hot hit vector over valid entries plus any-hit.
// Latency: purely combinational.
// Backpressure: none.
module ewb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [DEPTH-1:0]              i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  i_tags,
  output logic [DEPTH-1:0]              o_hit,
  output logic                          o_any
);

  // Compare the probe address against every valid tag
  always_comb begin
    o_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit[i] = i_valid[i] && (i_tags[i] == i_addr);
    end
  end

  assign o_any = |o_hit;

endmodule

// File: rtl/ewb_fifo.sv
// Multi-entry eviction write buffer: coalescing circular FIFO draining dirty lines to memory.
// Latency: push visible to lookup next cycle; drain starts one cycle after L2 frees the port.
// Backpressure: wr_ack low when full with no coalesce hit; drain yields to l2_mem_busy.
// Optional macro EWB_FWD_EN: forward matching buffered data to L2 reads.
module ewb_fifo
  import ewb_fifo_pkg::*;
#(
  parameter int DEPTH  = EWB_DEPTH_DEF,
  parameter int DATA_W = EWB_DATA_W_DEF,
  parameter int ADDR_W = EWB_ADDR_W_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  ewb_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;
  ewb_state_t                   r_state;
  ewb_state_t                   w_state_nxt;

  logic [DEPTH-1:0] w_head_oh;
  logic [DEPTH-1:0] w_inflight;
  logic [DEPTH-1:0] w_push_valid;
  logic [DEPTH-1:0] w_push_hit;
  logic [DEPTH-1:0] w_rd_hit;
  logic             w_push_any;
  logic             w_rd_any;
  logic             w_issue;
  logic             w_not_full;
  logic             w_alloc;
  logic             w_pop;

  // One-hot of the oldest entry, used to exclude it from coalescing while it is on the bus
  always_comb begin
    w_head_oh         = '0;
    w_head_oh[r_head] = 1'b1;
  end

  assign w_issue      = (r_state == ISSUE);
  assign w_inflight   = w_issue ? w_head_oh : '0;
  assign w_push_valid = r_valid & ~w_inflight;
  assign w_not_full   = (r_count != FULL_CNT);
  assign w_alloc      = bus.wr_req && !w_push_any && w_not_full;
  assign w_pop        = w_issue && bus.mem_ack;

  ewb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_push_match (
    .i_addr  (bus.wr_addr),
    .i_valid (w_push_valid),
    .i_tags  (r_addr),
    .o_hit   (w_push_hit),
    .o_any   (w_push_any)
  );

  ewb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_match (
    .i_addr  (bus.rd_addr),
    .i_valid (r_valid),
    .i_tags  (r_addr),
    .o_hit   (w_rd_hit),
    .o_any   (w_rd_any)
  );

  // Entry storage and pointers: coalesce in place, allocate at tail, retire at head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (bus.wr_req && w_push_any) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_push_hit[i]) r_data[i] <= bus.wr_data;
        end
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= bus.wr_addr;
        r_data[r_tail]  <= bus.wr_data;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
    end
  end

  // Drain state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Drain next-state and memory-port outputs; L2 always wins the port on a tie
  always_comb begin
    w_state_nxt  = r_state;
    bus.mem_req  = 1'b0;
    bus.ewb_busy = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0 && !bus.l2_mem_busy) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.mem_req  = 1'b1;
        bus.ewb_busy = 1'b1;
        if (bus.mem_ack) w_state_nxt = RETIRE;
      end
      RETIRE: begin
        bus.ewb_busy = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.wr_ack      = bus.wr_req && (w_push_any || w_not_full);
  assign bus.full        = (r_count == FULL_CNT);
  assign bus.empty       = (r_count == '0);
  assign bus.count       = r_count;
  assign bus.mem_addr    = r_addr[r_head];
  assign bus.mem_data    = r_data[r_head];
  assign bus.rd_conflict = w_rd_any;

`ifdef EWB_FWD_EN
  logic [DEPTH-1:0]  w_rd_young;
  logic [DATA_W-1:0] w_fwd_data;

  // Pick forwarded data: a younger copy supersedes the in-flight head
  always_comb begin
    w_rd_young = w_rd_hit & ~w_inflight;
    w_fwd_data = '0;
    if (|w_rd_young) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rd_young[i]) w_fwd_data = w_fwd_data | r_data[i];
      end
    end else if (w_rd_any) begin
      w_fwd_data = r_data[r_head];
    end
  end

  assign bus.rd_fwd_valid = w_rd_any;
  assign bus.rd_fwd_data  = w_fwd_data;
`else
  // Without forwarding the hit vector only feeds rd_conflict via any-hit
  logic w_rd_hit_unused;
  assign w_rd_hit_unused  = |w_rd_hit;
  assign bus.rd_fwd_valid = 1'b0;
  assign bus.rd_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ewb_fifo.sv
// Bench for ewb_fifo: queue-based reference model checked every cycle, plus directed scenarios.
// Latency: n/a.
// Backpressure: L2 side holds a push until the model says it is accepted.
module tb_ewb_fifo;

  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int DW    = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ewb_fifo_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ewb_fifo #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];    // buffered lines, oldest first
  ent_t mlog[$];  // lines written to memory, in order
  int   mphase;   // 0 idle, 1 write on the bus, 2 bubble after ack
  int   n_checks;
  int   n_err;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dat(input int v);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(v);
    return {w, w, w, w};
  endfunction

  // Index of a buffered line a push would coalesce into, or -1
  function automatic int find_coal(input logic [AW-1:0] a);
    int lo;
    lo = (mphase == 1) ? 1 : 0;
    for (int i = lo; i < mq.size(); i++) if (mq[i].a == a) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int n, ci, ri;
    logic [DW-1:0] fd;
    n  = mq.size();
    ci = find_coal(bus.wr_addr);
    ri = -1;
    for (int i = n - 1; i >= 0; i--) if (mq[i].a == bus.rd_addr) begin ri = i; break; end
    fd = (ri >= 0) ? mq[ri].d : '0;
    chk("count", bus.count, n);
    chk("full", bus.full, n == DEPTH);
    chk("empty", bus.empty, n == 0);
    chk("wr_ack", bus.wr_ack, bus.wr_req && (ci >= 0 || n < DEPTH));
    chk("rd_conflict", bus.rd_conflict, ri >= 0);
`ifdef EWB_FWD_EN
    chk("rd_fwd_valid", bus.rd_fwd_valid, ri >= 0);
    chk("rd_fwd_data", bus.rd_fwd_data, fd);
`else
    chk("rd_fwd_valid", bus.rd_fwd_valid, 1'b0);
    chk("rd_fwd_data", bus.rd_fwd_data, '0);
`endif
    chk("mem_req", bus.mem_req, mphase == 1);
    chk("ewb_busy", bus.ewb_busy, mphase != 0);
    if (mphase == 1) begin
      chk("mem_addr", bus.mem_addr, mq[0].a);
      chk("mem_data", bus.mem_data, mq[0].d);
    end
  endtask

  task automatic model_step();
    int n, ci;
    bit pop;
    ent_t e;
    n   = mq.size();
    ci  = find_coal(bus.wr_addr);
    pop = (mphase == 1) && bus.mem_ack;
    if (bus.wr_req) begin
      if (ci >= 0) begin
        e = mq[ci]; e.d = bus.wr_data; mq[ci] = e;
      end else if (n < DEPTH) begin
        e.a = bus.wr_addr; e.d = bus.wr_data; mq.push_back(e);
      end
    end
    if (pop) begin
      mlog.push_back(mq[0]);
      void'(mq.pop_front());
    end
    case (mphase)
      0: if (n > 0 && !bus.l2_mem_busy) mphase = 1;
      1: if (bus.mem_ack) mphase = 2;
      default: mphase = 0;
    endcase
  endtask

  // Inputs are set just after a falling edge; check, advance model, wait for next falling edge
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit busy, input bit ack);
    bus.wr_req      = wr;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    bus.l2_mem_busy = busy;
    bus.mem_ack     = ack;
  endtask

  task automatic drain_all();
    bit done;
    done = 0;
    drive(0, '0, '0, 0, 0);
    for (int c = 0; c < 200; c++) begin
      if (mq.size() == 0 && mphase == 0) begin done = 1; break; end
      bus.mem_ack = (mphase == 1) && ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("drain_done", done, 1'b1);
  endtask

  initial begin
    bit pend;
    ent_t e;
    n_checks = 0; n_err = 0; mphase = 0;
    drive(0, '0, '0, 0, 0);
    bus.rd_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_count", bus.count, 0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_ewb_busy", bus.ewb_busy, 1'b0);
    chk("rst_rd_conflict", bus.rd_conflict, 1'b0);
    chk("rst_fwd_valid", bus.rd_fwd_valid, 1'b0);
    chk("rst_fwd_data", bus.rd_fwd_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single line held off by L2, then drained
    drive(1, 12'h010, {16{8'hAA}}, 1, 0); #1 chk("t1_ack", bus.wr_ack, 1'b1); tick();
    drive(0, '0, '0, 1, 0); #1 chk("t1_count", bus.count, 1); chk("t1_noreq", bus.mem_req, 1'b0); tick();
    drive(0, '0, '0, 0, 0); #1 chk("t1_still_idle", bus.mem_req, 1'b0); tick();
    drive(0, '0, '0, 0, 1); #1
    chk("t1_req", bus.mem_req, 1'b1);
    chk("t1_addr", bus.mem_addr, 12'h010);
    chk("t1_data", bus.mem_data, {16{8'hAA}});
    tick();
    drive(0, '0, '0, 0, 0); #1
    chk("t1_cnt0", bus.count, 0); chk("t1_retire_busy", bus.ewb_busy, 1'b1); chk("t1_retire_req", bus.mem_req, 1'b0);
    tick();
    #1 chk("t1_idle_busy", bus.ewb_busy, 1'b0); tick();

    // Fill, reject on full, coalesce while full, drain in order
    for (int i = 1; i <= 4; i++) begin drive(1, AW'(i), dat(i), 1, 0); tick(); end
    #1 chk("t2_full", bus.full, 1'b1); chk("t2_cnt4", bus.count, 4);
    drive(1, 12'h005, dat(5), 1, 0); #1 chk("t2_reject", bus.wr_ack, 1'b0); tick();
    drive(1, 12'h002, {16{8'hBB}}, 1, 0); #1 chk("t2_coal_ack", bus.wr_ack, 1'b1); tick();
    drive(0, '0, '0, 1, 0); #1 chk("t2_cnt_kept", bus.count, 4); tick();
    mlog.delete();
    drain_all();
    chk("t2_nlog", mlog.size(), 4);
    if (mlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", mlog[i].a, AW'(i + 1));
      chk("t2_coal_data", mlog[1].d, {16{8'hBB}});
    end

    // Push to the address currently on the bus allocates a fresh entry
    drive(1, 12'h001, {16{8'h11}}, 1, 0); tick();
    drive(0, '0, '0, 0, 0); tick();
    mlog.delete();
    drive(1, 12'h001, {16{8'h22}}, 0, 0); #1
    chk("t3_issuing", bus.mem_req, 1'b1); chk("t3_ack", bus.wr_ack, 1'b1); tick();
    drive(0, '0, '0, 1, 0); #1 chk("t3_cnt2", bus.count, 2); tick();
    drain_all();
    chk("t3_nlog", mlog.size(), 2);
    if (mlog.size() == 2) begin
      chk("t3_first", mlog[0].d, {16{8'h11}});
      chk("t3_second", mlog[1].d, {16{8'h22}});
    end

    // Read lookup
    drive(1, 12'h003, {16{8'h33}}, 1, 0); tick();
    drive(0, '0, '0, 1, 0); bus.rd_addr = 12'h003; #1
    chk("t4_conflict", bus.rd_conflict, 1'b1);
`ifdef EWB_FWD_EN
    chk("t4_fwd_valid", bus.rd_fwd_valid, 1'b1);
    chk("t4_fwd_data", bus.rd_fwd_data, {16{8'h33}});
`else
    chk("t4_fwd_valid", bus.rd_fwd_valid, 1'b0);
`endif
    bus.rd_addr = 12'h005; #1 chk("t4_no_conflict", bus.rd_conflict, 1'b0);
    tick();
    bus.rd_addr = '0;
    drain_all();

    // L2 wins tie, then reset mid-write
    drive(1, 12'h007, dat(7), 1, 0); tick();
    drive(0, '0, '0, 1, 0); #1 chk("t5_idle_a", bus.mem_req, 1'b0); tick();
    drive(0, '0, '0, 0, 0); #1 chk("t5_idle_b", bus.mem_req, 1'b0); tick();
    #1 chk("t5_issue", bus.mem_req, 1'b1);
    rst_n = 1'b0; #1
    chk("t5_rst_req", bus.mem_req, 1'b0);
    chk("t5_rst_empty", bus.empty, 1'b1);
    chk("t5_rst_count", bus.count, 0);
    chk("t5_rst_busy", bus.ewb_busy, 1'b0);
    mq.delete(); mphase = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Push and retire in the same cycle across the pointer wrap
    for (int i = 0; i < 3; i++) begin drive(1, AW'(12'h020 + i), dat(32 + i), 1, 0); tick(); end
    drain_all();
    drive(1, 12'h030, dat(48), 1, 0); tick();
    drive(1, 12'h031, dat(49), 1, 0); tick();
    drive(0, '0, '0, 0, 0); tick();
    mlog.delete();
    drive(1, 12'h032, dat(50), 0, 1); #1
    chk("t6_ack", bus.wr_ack, 1'b1); chk("t6_req", bus.mem_req, 1'b1); tick();
    drive(0, '0, '0, 1, 0); #1 chk("t6_cnt2", bus.count, 2); tick();
    drain_all();
    chk("t6_nlog", mlog.size(), 3);
    if (mlog.size() == 3) for (int i = 0; i < 3; i++) chk("t6_order", mlog[i].a, AW'(12'h030 + i));

    // Randomized traffic against the model
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        bus.wr_req  = ($urandom_range(0, 1) == 1);
        bus.wr_addr = AW'(12'h040 + $urandom_range(0, 7));
        bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.rd_addr     = AW'(12'h040 + $urandom_range(0, 7));
      bus.l2_mem_busy = ($urandom_range(0, 9) < 3);
      bus.mem_ack     = (mphase == 1) && ($urandom_range(0, 1) == 1);
      pend = bus.wr_req && !(find_coal(bus.wr_addr) >= 0 || mq.size() < DEPTH);
      tick();
    end
    bus.rd_addr = '0;
    drain_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ewb_fifo.md
Name: ewb_fifo

Overview:
Parametrised, multi-entry successor to the single-line eviction write buffer between L2 and physical memory. Holds up to DEPTH dirty cache lines in a circular FIFO, coalesces repeated writes to a buffered line, and drains to memory only when L2 is not using the shared memory port. Provides an address lookup so L2 reads never bypass a pending write.

Parameters:
DEPTH, 4, number of line entries; power of two, >= 2
DATA_W, 128, cache line width in bits
ADDR_W, 12, line address width (lc3b_cline_addr)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  L2 requests to push an evicted line
wr_addr  in  ADDR_W  line address of push
wr_data  in  DATA_W  line data of push
wr_ack  out  1  push accepted this cycle (combinational)
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH+1)  valid entries
rd_addr  in  ADDR_W  L2 read/miss address for lookup
rd_conflict  out  1  rd_addr matches a valid entry
rd_fwd_valid  out  1  forwarded data valid (EWB_FWD_EN only)
rd_fwd_data  out  DATA_W  data of matching entry
l2_mem_busy  in  1  L2 owns memory port this cycle; asserted combinationally in the cycle L2 starts an access
ewb_busy  out  1  buffer owns memory port (state != IDLE)
mem_req  out  1  write request to memory
mem_addr  out  ADDR_W  head entry address
mem_data  out  DATA_W  head entry data
mem_ack  in  1  memory completed write

Behaviour:
- Reset (rst_n low, async): all valid bits 0, head/tail/count 0, state IDLE; wr_ack 0, full 0, empty 1, mem_req 0, ewb_busy 0, rd_conflict 0, rd_fwd_valid 0, rd_fwd_data 0. Reset mid-write drops mem_req immediately; the write is lost by design.
- Storage: circular array, head = oldest, tail = next free; pointers wrap modulo DEPTH.
- Push: match = wr_addr equals a valid entry that is not the in-flight head (head while state == ISSUE).
  - match: overwrite that entry's data in place, count unchanged, wr_ack 1.
  - no match and count < DEPTH: write at tail, tail+1, count+1, wr_ack 1.
  - otherwise wr_ack 0; L2 holds wr_req/addr/data until acked.
  - full and count use registered count; pop and push in same cycle: count unchanged net.
- Drain FSM (ewb_state_t):
  - IDLE: if !empty and !l2_mem_busy -> ISSUE. l2_mem_busy wins same-cycle ties.
  - ISSUE: mem_req 1, ewb_busy 1, mem_addr/mem_data = head, stable until mem_ack. On mem_ack: head valid cleared, head+1, count-1 -> RETIRE.
  - RETIRE: mem_req 0, ewb_busy 1, one bubble cycle for memory to deassert ack -> IDLE.
  - Back-to-back drains therefore cost >= 3 cycles per line (ISSUE min 1, RETIRE 1, IDLE 1).
- Lookup (combinational): rd_conflict = rd_addr matches any valid entry including in-flight head. Coalescing guarantees at most one match outside the in-flight head; if both head and a younger entry match, younger wins for rd_fwd_data.
- L2 rule: L2 must not issue a memory read to an address while rd_conflict is 1 unless rd_fwd_valid is 1.

Optional Feature:
EWB_FWD_EN
- defined: on rd_conflict, rd_fwd_valid 1 and rd_fwd_data = matching entry data; L2 fills from the buffer without memory access.
- undefined: rd_fwd_valid tied 0, rd_fwd_data tied 0; L2 stalls on rd_conflict until the entry drains. rd_conflict logic always present.

Decomposition:
- lc3b_types: add ewb_state_t {IDLE, ISSUE, RETIRE}; reuse lc3b_cline (128b) and line address type for DATA_W/ADDR_W defaults.
- One sub-module: ewb_match, DEPTH-way address comparator returning one-hot match vector plus any-hit; instantiated twice (push coalescing, read lookup).

Test Plan:
- Reset then push A=0x010 D=0xAA.. with l2_mem_busy=1 -> wr_ack 1, count 1, mem_req stays 0; release busy -> mem_req next cycle with addr 0x010, data 0xAA.., mem_ack -> count 0, ewb_busy 1 one more cycle, then 0.
- Four pushes 0x001..0x004 with l2_mem_busy=1 -> full 1; fifth push 0x005 -> wr_ack 0; push 0x002 data 0xBB.. -> wr_ack 1, count stays 4; drain shows order 0x001,0x002(0xBB..),0x003,0x004.
- Entry 0x001 in ISSUE, push 0x001 new data -> new entry allocated (count +1); both written to memory in order.
- rd_addr 0x003 buffered -> rd_conflict 1; with EWB_FWD_EN rd_fwd_valid 1 and data matches; without, rd_fwd_valid 0.
- l2_mem_busy and drain start same cycle -> FSM stays IDLE, mem_req 0; assert rst_n low during ISSUE -> mem_req 0 immediately, empty 1, count 0.
- Push and mem_ack in same cycle at count 2 -> count stays 2, tail and head both wrap correctly past DEPTH-1.
